// File: rtl/conv_pkg.sv
// Shared definitions for the convolution patch scheduler: FSM state encoding,
// kernel tap count and tap index width.
package conv_pkg;

  localparam int KERNEL_TAPS = 9;
  localparam int TAP_IDX_W   = 4;

  localparam logic [KERNEL_TAPS-1:0] TAP_MASK_FULL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KERNEL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic tap_idx_valid(input logic [TAP_IDX_W-1:0] idx);
    return idx < TAP_IDX_W'(KERNEL_TAPS);
  endfunction

endpackage

// File: rtl/conv_pipe_tracker.sv
// Shift register that mirrors the multiplication core pipeline: carries a
// valid bit plus a payload per stage and advances only while enabled.
module conv_pipe_tracker #(
  parameter int PIPE_LAT  = 3,
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_vld,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_vld,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 empty
);

  logic [PIPE_LAT-1:0]  vld_q, vld_d, src_vld;
  logic [PAYLOAD_W-1:0] data_q [PIPE_LAT];
  logic [PAYLOAD_W-1:0] data_d [PIPE_LAT];
  logic [PAYLOAD_W-1:0] src_data [PIPE_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_vld[gi]  = in_vld;
        assign src_data[gi] = in_data;
      end else begin : g_body
        assign src_vld[gi]  = vld_q[gi-1];
        assign src_data[gi] = data_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    vld_d = en ? src_vld : vld_q;
    // A clear must also drop the stage being loaded this cycle.
    if (clr) begin
      vld_d = '0;
    end
    for (int i = 0; i < PIPE_LAT; i++) begin
      data_d[i] = en ? src_data[i] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_vld  = vld_q[PIPE_LAT-1];
  assign out_data = data_q[PIPE_LAT-1];
  assign empty    = ~|vld_q;

endmodule

// File: rtl/conv_patch_scheduler.sv
// Sequences a convolution job: loads the 3x3 kernel, issues grid patches
// row-major to the multiplication core and tracks results to the consumer.
module conv_patch_scheduler
  import conv_pkg::*;
#(
  parameter int FMS_PATCH_SIZE    = 4,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int PIPE_LAT          = 3,
  parameter int IDX_W             = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [IDX_W-1:0]                    cfg_rows,
  input  logic [IDX_W-1:0]                    cfg_cols,
  input  logic                                kwr_vld,
  input  logic [TAP_IDX_W-1:0]                kwr_idx,
  input  logic signed [KERNEL_DATA_WIDTH-1:0] kwr_x,
  input  logic signed [KERNEL_DATA_WIDTH-1:0] kwr_y,
  input  logic                                patch_vld,
  output logic                                patch_rdy,
  output logic                                core_clk_en,
  output logic                                core_data_vld,
  output logic signed [KERNEL_DATA_WIDTH-1:0] kernel_x [KERNEL_TAPS],
  output logic signed [KERNEL_DATA_WIDTH-1:0] kernel_y [KERNEL_TAPS],
  output logic                                res_vld,
  input  logic                                res_rdy,
  output logic [IDX_W-1:0]                    res_row,
  output logic [IDX_W-1:0]                    res_col,
  output logic                                res_last,
  output logic                                busy,
  output logic                                done
);

  localparam int PAY_W = 2 * IDX_W + 1;

  generate
    if (PIPE_LAT < 1 || FMS_PATCH_SIZE < 1) begin : g_param_check
      $error("conv_patch_scheduler: PIPE_LAT and FMS_PATCH_SIZE must be >= 1");
    end
  endgenerate

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               rows_q, rows_d, cols_q, cols_d;
  logic [IDX_W-1:0]               row_q, row_d, col_q, col_d;
  logic [KERNEL_TAPS-1:0]         mask_q, mask_d;
  logic signed [KERNEL_DATA_WIDTH-1:0] kx_q [KERNEL_TAPS];
  logic signed [KERNEL_DATA_WIDTH-1:0] kx_d [KERNEL_TAPS];
  logic signed [KERNEL_DATA_WIDTH-1:0] ky_q [KERNEL_TAPS];
  logic signed [KERNEL_DATA_WIDTH-1:0] ky_d [KERNEL_TAPS];

  logic             stall, issue, is_last;
  logic             tail_vld, pipe_empty;
  logic [PAY_W-1:0] tail_data;

  always_comb begin
    stall     = tail_vld & ~res_rdy;
    is_last   = (row_q == rows_q - IDX_W'(1)) && (col_q == cols_q - IDX_W'(1));
    patch_rdy = (state_q == ST_RUN) & ~stall;
    issue     = patch_vld & patch_rdy;

    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    mask_d  = mask_q;
    kx_d    = kx_q;
    ky_d    = ky_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_d  = cfg_rows;
            cols_d  = cfg_cols;
            row_d   = '0;
            col_d   = '0;
            mask_d  = '0;
            state_d = ST_LOAD_KERNEL;
          end
        end
        ST_LOAD_KERNEL: begin
          if (kwr_vld && tap_idx_valid(kwr_idx)) begin
            for (int t = 0; t < KERNEL_TAPS; t++) begin
              if (kwr_idx == TAP_IDX_W'(t)) begin
                kx_d[t]   = kwr_x;
                ky_d[t]   = kwr_y;
                mask_d[t] = 1'b1;
              end
            end
          end
          // An empty grid still completes the job, just without issuing.
          if (mask_d == TAP_MASK_FULL) begin
            state_d = (rows_q == '0 || cols_q == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (is_last) begin
              state_d = ST_DRAIN;
            end else if (col_q == cols_q - IDX_W'(1)) begin
              col_d = '0;
              row_d = row_q + IDX_W'(1);
            end else begin
              col_d = col_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mask_q  <= '0;
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        kx_q[t] <= '0;
        ky_q[t] <= '0;
      end
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mask_q  <= mask_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
    end
  end

  conv_pipe_tracker #(
    .PIPE_LAT  (PIPE_LAT),
    .PAYLOAD_W (PAY_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .en       (~stall),
    .clr      (abort),
    .in_vld   (issue),
    .in_data  ({is_last, row_q, col_q}),
    .out_vld  (tail_vld),
    .out_data (tail_data),
    .empty    (pipe_empty)
  );

  assign core_clk_en   = ~stall;
  assign core_data_vld = issue;
  assign kernel_x      = kx_q;
  assign kernel_y      = ky_q;
  assign res_vld       = tail_vld;
  assign res_last      = tail_data[PAY_W-1];
  assign res_row       = tail_data[2*IDX_W-1:IDX_W];
  assign res_col       = tail_data[IDX_W-1:0];
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Scoreboard bench for conv_patch_scheduler: directed jobs push expected
// results into a queue, an independent monitor pops and compares them.
module tb_conv_patch_scheduler;

  localparam int KW    = 8;
  localparam int IDX_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [IDX_W-1:0] cfg_rows = '0, cfg_cols = '0;
  logic kwr_vld = 1'b0;
  logic [3:0] kwr_idx = '0;
  logic signed [KW-1:0] kwr_x = '0, kwr_y = '0;
  logic patch_vld = 1'b0, patch_rdy;
  logic core_clk_en, core_data_vld;
  logic signed [KW-1:0] kernel_x [9];
  logic signed [KW-1:0] kernel_y [9];
  logic res_vld, res_rdy = 1'b1, res_last;
  logic [IDX_W-1:0] res_row, res_col;
  logic busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  res_t exp_q [$];

  conv_patch_scheduler #(
    .FMS_PATCH_SIZE(4), .KERNEL_DATA_WIDTH(KW), .PIPE_LAT(3), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .kwr_vld(kwr_vld), .kwr_idx(kwr_idx), .kwr_x(kwr_x), .kwr_y(kwr_y),
    .patch_vld(patch_vld), .patch_rdy(patch_rdy),
    .core_clk_en(core_clk_en), .core_data_vld(core_data_vld),
    .kernel_x(kernel_x), .kernel_y(kernel_y),
    .res_vld(res_vld), .res_rdy(res_rdy),
    .res_row(res_row), .res_col(res_col), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: one line per transferred result.
  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got (%0d,%0d,last=%0d) expected none",
                 res_row, res_col, res_last);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        $display("result (%0d,%0d) last=%0d cycle %0d", res_row, res_col, res_last, cyc);
        chk("res_row", int'(res_row), int'(e.row));
        chk("res_col", int'(res_col), int'(e.col));
        chk("res_last", int'(res_last), int'(e.last));
      end
    end
  end

  task automatic start_job(input int rows, input int cols);
    cfg_rows = IDX_W'(rows);
    cfg_cols = IDX_W'(cols);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic write_tap(input int idx, input int val);
    kwr_vld = 1'b1;
    kwr_idx = 4'(idx);
    kwr_x   = KW'(val);
    kwr_y   = KW'(-val);
    @(posedge clk); #1;
    kwr_vld = 1'b0;
  endtask

  task automatic load_all(input int base);
    for (int t = 0; t < 9; t++) write_tap(t, base + t);
  endtask

  task automatic wait_done(input string name, input int bound);
    int seen = 0;
    for (int k = 0; k < bound && seen == 0; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(name, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic push(input int r, input int c, input int l);
    res_t e;
    e.row = IDX_W'(r); e.col = IDX_W'(c); e.last = l[0];
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_issue, t_res, ni, prd_cnt, rv_cnt, dn0;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_patch_rdy", patch_rdy, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_core_clk_en", core_clk_en, 1);
    chk("rst_kernel_x0", kernel_x[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Job 1: 3x2 grid, taps 1..9, latency check
    push(0,0,0); push(0,1,0); push(1,0,0); push(1,1,0); push(2,0,0); push(2,1,1);
    patch_vld = 1'b1;
    dn0 = done_cnt;
    start_job(3, 2);
    chk("busy_after_start", busy, 1);
    load_all(1);
    chk("kernel_x0", kernel_x[0], 1);
    chk("kernel_y8", kernel_y[8], -9);
    t_issue = -1; t_res = -1;
    for (int k = 0; k < 20 && t_res < 0; k++) begin
      @(negedge clk);
      if (core_data_vld && t_issue < 0) t_issue = cyc;
      if (res_vld && t_res < 0) t_res = cyc;
    end
    chk("latency", t_res - t_issue, 3);
    wait_done("job1_done", 40);
    repeat (3) @(posedge clk); #1;
    chk("job1_done_count", done_cnt - dn0, 1);
    chk("job1_queue_empty", exp_q.size(), 0);
    chk("job1_idle", busy, 0);

    // Job 2: 3x3 grid with a 4-cycle downstream stall
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) push(r, c, (r == 2 && c == 2) ? 1 : 0);
    start_job(3, 3);
    load_all(20);
    t_res = -1;
    for (int k = 0; k < 20 && t_res < 0; k++) begin
      @(negedge clk);
      if (res_vld) t_res = cyc;
    end
    chk("job2_first_res", int'(t_res >= 0), 1);
    @(posedge clk); #1;
    res_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("stall_core_clk_en", core_clk_en, 0);
      chk("stall_patch_rdy", patch_rdy, 0);
      chk("stall_core_data_vld", core_data_vld, 0);
      chk("stall_res_vld", res_vld, 1);
      chk("stall_res_row", res_row, 0);
      chk("stall_res_col", res_col, 1);
    end
    @(posedge clk); #1;
    res_rdy = 1'b1;
    wait_done("job2_done", 60);
    chk("job2_queue_empty", exp_q.size(), 0);

    // Kernel writes in IDLE are ignored
    write_tap(0, 77);
    @(negedge clk);
    chk("idle_kwr_ignored", kernel_x[0], 20);
    @(posedge clk); #1;

    // Job 3: 1x3 grid, incomplete mask then invalid index, then tap 8
    push(0,0,0); push(0,1,0); push(0,2,1);
    start_job(1, 3);
    for (int t = 0; t < 8; t++) write_tap(t, 40 + t);
    write_tap(12, 99);
    @(negedge clk);
    chk("mask_incomplete_patch_rdy", patch_rdy, 0);
    chk("mask_incomplete_busy", busy, 1);
    @(posedge clk); #1;
    write_tap(8, 48);
    @(negedge clk);
    chk("mask_full_patch_rdy", patch_rdy, 1);
    chk("mask_full_issue", core_data_vld, 1);
    chk("tap8_x", kernel_x[8], 48);
    chk("tap8_y", kernel_y[8], -48);
    @(posedge clk); #1;
    wait_done("job3_done", 40);
    chk("job3_queue_empty", exp_q.size(), 0);

    // Job 4: zero rows -> done without any patch or result
    start_job(0, 5);
    load_all(2);
    prd_cnt = 0; rv_cnt = 0; ni = 0;
    for (int k = 0; k < 20 && ni == 0; k++) begin
      @(negedge clk);
      if (patch_rdy) prd_cnt++;
      if (res_vld) rv_cnt++;
      if (done) ni = 1;
    end
    chk("zero_rows_done", ni, 1);
    chk("zero_rows_patch_rdy", prd_cnt, 0);
    chk("zero_rows_res_vld", rv_cnt, 0);
    @(posedge clk); #1;

    // Job 5: abort with two patches in flight
    start_job(4, 4);
    load_all(60);
    ni = 0;
    for (int k = 0; k < 20 && ni < 2; k++) begin
      @(negedge clk);
      if (core_data_vld) ni++;
    end
    chk("abort_two_issued", ni, 2);
    @(posedge clk); #1;
    patch_vld = 1'b0;
    abort = 1'b1; start = 1'b1;
    kwr_vld = 1'b1; kwr_idx = 4'd0; kwr_x = 8'sd5; kwr_y = 8'sd5;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; kwr_vld = 1'b0;
    dn0 = done_cnt;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_res_vld", res_vld, 0);
    chk("abort_kwr_blocked", kernel_x[0], 60);
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (res_vld || done) rv_cnt++;
    end
    chk("abort_quiet", rv_cnt, 0);
    chk("abort_no_done", done_cnt - dn0, 0);
    @(posedge clk); #1;

    // Job 6: clean job after abort, 2x1 grid
    push(0,0,0); push(1,0,1);
    patch_vld = 1'b1;
    start_job(2, 1);
    load_all(3);
    wait_done("job6_done", 40);
    chk("job6_queue_empty", exp_q.size(), 0);

    // Job 7: asynchronous reset in DRAIN
    push(0,0,0); push(0,1,0); push(1,0,0); push(1,1,1);
    start_job(2, 2);
    load_all(5);
    ni = 0;
    for (int k = 0; k < 20 && ni < 4; k++) begin
      @(negedge clk);
      if (core_data_vld) ni++;
    end
    chk("drain_four_issued", ni, 4);
    @(posedge clk); #1;
    chk("drain_busy", busy, 1);
    chk("drain_patch_rdy", patch_rdy, 0);
    chk("drain_res_vld", res_vld, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_res_vld", res_vld, 0);
    chk("arst_res_last", res_last, 0);
    chk("arst_res_row", res_row, 0);
    chk("arst_res_col", res_col, 0);
    chk("arst_patch_rdy", patch_rdy, 0);
    chk("arst_core_data_vld", core_data_vld, 0);
    chk("arst_done", done, 0);
    chk("arst_core_clk_en", core_clk_en, 1);
    chk("arst_kernel_x4", kernel_x[4], 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    patch_vld = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
